counter_bank: RTL and testbench

- Parametrised multi-channel down-counter bank; successor to the single 32-bit latch/decrement/zero counter.
- NUM_CH independent WIDTH-bit channels share one load port. Each channel has its own decrement strobe, zero flag and terminal-count pulse.
- Adds per-channel auto-reload mode and a registered readback port.
- Used as the general timer/event-count resource for datapath control FSMs.

---
 rtl/counter_pkg.sv | 23 ++
 rtl/counter_chan.sv | 51 +++++
 rtl/counter_bank.sv | 65 ++++++
 tb/tb_counter_bank.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter bank: channel mode encoding and a
// constant log2 helper used to size channel-select ports.
package counter_pkg;

    typedef enum logic {
        MODE_ONESHOT = 1'b0,
        MODE_RELOAD  = 1'b1
    } mode_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_chan.sv
// One saturating down-counter channel with optional auto-reload and a
// registered terminal-count pulse on the 1 -> 0 (or 1 -> reload) step.
module counter_chan
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  mode_t            ld_mode,
    input  logic             dec,
    output logic             zero,
    output logic             tc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] reload_reg;
    mode_t            mode;

    // Count, reload value, mode and tc pulse; reset > load > dec > hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            reload_reg <= '0;
            mode       <= MODE_ONESHOT;
            tc         <= 1'b0;
        end else if (ld) begin
            count      <= ld_val;
            reload_reg <= ld_val;
            mode       <= ld_mode;
            tc         <= 1'b0;
        end else if (dec) begin
            if (count == '0) begin
                tc <= 1'b0;
            end else if (count == WIDTH'(1)) begin
                count <= (mode == MODE_RELOAD) ? reload_reg : '0;
                tc    <= 1'b1;
            end else begin
                count <= count - WIDTH'(1);
                tc    <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent down-counter channels sharing one load port,
// with per-channel decrement/zero/tc and a registered readback mux.
module counter_bank
    import counter_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned CH_W   = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              reload_en,
    input  logic [NUM_CH-1:0] dec,
    output logic [NUM_CH-1:0] zero,
    output logic [NUM_CH-1:0] tc,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [WIDTH-1:0]  rd_val
);

    logic [WIDTH-1:0]  counts [NUM_CH];
    logic [NUM_CH-1:0] ld;
    logic [WIDTH-1:0]  rd_next;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        // Out-of-range load_ch matches no channel, so such loads are dropped.
        assign ld[g] = load && (load_ch == CH_W'(g));

        counter_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .ld     (ld[g]),
            .ld_val (load_val),
            .ld_mode(mode_t'(reload_en)),
            .dec    (dec[g]),
            .zero   (zero[g]),
            .tc     (tc[g]),
            .count  (counts[g])
        );
    end

    // Readback select; an out-of-range rd_ch leaves the default of zero.
    always_comb begin
        rd_next = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_next = counts[i];
            end
        end
    end

    // Register the pre-update count of the selected channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_val <= '0;
        end else begin
            rd_val <= rd_next;
        end
    end

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank with a scoreboard of expected outputs:
// a 4-channel 32-bit instance checked against a behavioural model plus
// directed constants, and a 3-channel 8-bit instance for out-of-range selects.
module tb_counter_bank;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned BN = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          load;
    logic [1:0]    load_ch;
    logic [W-1:0]  load_val;
    logic          reload_en;
    logic [N-1:0]  dec;
    logic [N-1:0]  zero;
    logic [N-1:0]  tc;
    logic [1:0]    rd_ch;
    logic [W-1:0]  rd_val;

    logic          b_load;
    logic [1:0]    b_load_ch;
    logic [BN-1:0] b_dec;
    logic [BN-1:0] b_zero;
    logic [BN-1:0] b_tc;
    logic [1:0]    b_rd_ch;
    logic [BW-1:0] b_rd_val;

    always #5 clock = ~clock;

    counter_bank #(.WIDTH(W), .NUM_CH(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_ch  (load_ch),
        .load_val (load_val),
        .reload_en(reload_en),
        .dec      (dec),
        .zero     (zero),
        .tc       (tc),
        .rd_ch    (rd_ch),
        .rd_val   (rd_val)
    );

    counter_bank #(.WIDTH(BW), .NUM_CH(BN)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .load     (b_load),
        .load_ch  (b_load_ch),
        .load_val (load_val[BW-1:0]),
        .reload_en(reload_en),
        .dec      (b_dec),
        .zero     (b_zero),
        .tc       (b_tc),
        .rd_ch    (b_rd_ch),
        .rd_val   (b_rd_val)
    );

    typedef enum int {K_ZERO, K_TC, K_RD, K_ZBIT, K_TBIT, K_BZERO, K_BTC, K_BRD} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        int unsigned idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state for the 4-channel instance.
    logic [W-1:0] m_cnt [N];
    logic [W-1:0] m_rel [N];
    logic         m_mode [N];
    logic [N-1:0] m_tc;
    logic [W-1:0] m_rd;

    function automatic void push(string tag, kind_t k, int unsigned idx, logic [31:0] e);
        exp_t x;
        x.tag  = tag;
        x.kind = k;
        x.idx  = idx;
        x.exp  = e;
        sb.push_back(x);
    endfunction

    function automatic logic [31:0] observe(kind_t k, int unsigned idx);
        case (k)
            K_ZERO:  return {28'b0, zero};
            K_TC:    return {28'b0, tc};
            K_RD:    return rd_val;
            K_ZBIT:  return {31'b0, zero[idx]};
            K_TBIT:  return {31'b0, tc[idx]};
            K_BZERO: return {29'b0, b_zero};
            K_BTC:   return {29'b0, b_tc};
            K_BRD:   return {24'b0, b_rd_val};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind, e.idx), e.exp);
        end
    endtask

    // Advance the model by one edge using the inputs now applied and
    // queue the outputs it predicts for after that edge.
    task automatic model_edge();
        logic [N-1:0] zv;
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                m_cnt[i]  = '0;
                m_rel[i]  = '0;
                m_mode[i] = 1'b0;
            end
            m_tc = '0;
            m_rd = '0;
        end else begin
            m_rd = m_cnt[rd_ch];
            for (int unsigned i = 0; i < N; i++) begin
                m_tc[i] = 1'b0;
                if (load && (int'(load_ch) == int'(i))) begin
                    m_cnt[i]  = load_val;
                    m_rel[i]  = load_val;
                    m_mode[i] = reload_en;
                end else if (dec[i]) begin
                    if (m_cnt[i] == 1) begin
                        m_tc[i]  = 1'b1;
                        m_cnt[i] = m_mode[i] ? m_rel[i] : '0;
                    end else if (m_cnt[i] != 0) begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
        end
        for (int unsigned i = 0; i < N; i++) zv[i] = (m_cnt[i] == 0);
        push("model_zero", K_ZERO, 0, {28'b0, zv});
        push("model_tc", K_TC, 0, {28'b0, m_tc});
        push("model_rd", K_RD, 0, m_rd);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        drain();
    endtask

    int unsigned os_rd [5] = '{3, 2, 1, 0, 0};
    int          pulses;
    int          zseen;

    initial begin
        for (int unsigned i = 0; i < N; i++) begin
            m_cnt[i] = '0; m_rel[i] = '0; m_mode[i] = 1'b0;
        end
        m_tc = '0; m_rd = '0;

        reset = 1'b1; load = 1'b0; load_ch = '0; load_val = '0; reload_en = 1'b0;
        dec = '0; rd_ch = '0;
        b_load = 1'b0; b_load_ch = '0; b_dec = '0; b_rd_ch = '0;

        // Reset state
        tick();
        push("rst_zero", K_ZERO, 0, 32'hF);
        push("rst_tc", K_TC, 0, 32'h0);
        push("rst_rd", K_RD, 0, 32'h0);
        push("rst_b_zero", K_BZERO, 0, 32'h7);
        push("rst_b_rd", K_BRD, 0, 32'h0);
        tick();
        reset = 1'b0;

        // Decrement from zero saturates with no tc
        dec = 4'hF;
        push("sat_zero", K_ZERO, 0, 32'hF);
        push("sat_tc", K_TC, 0, 32'h0);
        tick();
        push("sat_tc2", K_TC, 0, 32'h0);
        tick();
        dec = '0;

        // One-shot: ch1 = 3, dec for 5 cycles
        load = 1'b1; load_ch = 2'd1; load_val = 3; reload_en = 1'b0;
        tick();
        load = 1'b0; rd_ch = 2'd1; dec = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            push("os_rd", K_RD, 0, os_rd[k]);
            push("os_tc1", K_TBIT, 1, (k == 2) ? 32'd1 : 32'd0);
            push("os_zero1", K_ZBIT, 1, (k >= 2) ? 32'd1 : 32'd0);
            tick();
        end
        dec = '0;

        // Auto-reload: ch2 = 4, dec for 12 cycles
        load = 1'b1; load_ch = 2'd2; load_val = 4; reload_en = 1'b1;
        tick();
        load = 1'b0; reload_en = 1'b0; dec = 4'b0100; rd_ch = 2'd2;
        pulses = 0; zseen = 0;
        for (int k = 0; k < 12; k++) begin
            push("ar_tc2", K_TBIT, 2, ((k % 4) == 3) ? 32'd1 : 32'd0);
            push("ar_zero2", K_ZBIT, 2, 32'd0);
            tick();
            pulses += int'(tc[2]);
            zseen  += int'(zero[2]);
        end
        check("ar_pulse_count", pulses, 3);
        check("ar_zero_seen", zseen, 0);
        dec = '0;

        // Collision: load ch0 = 10 while dec[0] with count0 == 1
        load = 1'b1; load_ch = 2'd0; load_val = 1; reload_en = 1'b0;
        tick();
        load_val = 10; dec = 4'b0001;
        push("col_tc0", K_TBIT, 0, 32'd0);
        push("col_zero0", K_ZBIT, 0, 32'd0);
        tick();
        load = 1'b0; dec = '0; rd_ch = 2'd0;
        push("col_rd0", K_RD, 0, 32'd10);
        tick();

        // Independence: ch0 = 2, ch3 = 2, dec together
        load = 1'b1; load_ch = 2'd0; load_val = 2;
        tick();
        load_ch = 2'd3;
        tick();
        load = 1'b0; dec = 4'b1001;
        push("ind_tc_a", K_TC, 0, 32'h0);
        tick();
        push("ind_tc_b", K_TC, 0, 32'h9);
        push("ind_zero", K_ZERO, 0, 32'hB);
        tick();
        dec = '0; rd_ch = 2'd1;
        push("ind_tc_c", K_TC, 0, 32'h0);
        push("ind_rd1", K_RD, 0, 32'd0);
        tick();
        rd_ch = 2'd2;
        push("ind_rd2", K_RD, 0, 32'd4);
        tick();

        // Reset while count1 == 1 and dec[1] high
        load = 1'b1; load_ch = 2'd1; load_val = 2; reload_en = 1'b0;
        tick();
        load = 1'b0; dec = 4'b0010; rd_ch = 2'd1;
        tick();
        reset = 1'b1;
        push("mid_tc", K_TC, 0, 32'h0);
        push("mid_zero", K_ZERO, 0, 32'hF);
        push("mid_rd", K_RD, 0, 32'h0);
        tick();
        reset = 1'b0;
        push("mid_tc2", K_TC, 0, 32'h0);
        tick();
        push("mid_tc3", K_TC, 0, 32'h0);
        push("mid_zero3", K_ZERO, 0, 32'hF);
        tick();
        dec = '0;

        // Out-of-range selects on the 3-channel instance
        b_load = 1'b1; b_load_ch = 2'd3; load_val = 7;
        push("oor_ld_zero", K_BZERO, 0, 32'h7);
        push("oor_ld_tc", K_BTC, 0, 32'h0);
        tick();
        b_load_ch = 2'd0; load_val = 9;
        tick();
        b_load = 1'b0; b_rd_ch = 2'd3;
        push("oor_rd", K_BRD, 0, 32'd0);
        push("b_zero_ch0", K_BZERO, 0, 32'h6);
        tick();
        b_rd_ch = 2'd0;
        push("b_rd0", K_BRD, 0, 32'd9);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
